dientry: RTL

Keystroke entry sequencer that drives the digital clock datapath's load interface. It accepts ASCII bytes from the serial receiver, parses a command character followed by four decimal digits, and issues per-digit load strobes for either the running time or the alarm. The design is a five-state FSM with a registered one-cycle load pulse, range checking, abort handling and an optional inactivity timeout.

---
 rtl/de_pkg.sv | 25 ++
 rtl/entry_timer.sv | 24 ++
 rtl/dientry.sv | 112 +++++++++++
 3 files changed

// File: rtl/de_pkg.sv
// Shared types and ASCII constants for the keystroke entry sequencer.
package de_pkg;

    typedef enum logic [2:0] {IDLE, MT, MO, ST, SO} state_t;

    localparam logic [7:0] CMD_TIME_L  = 8'h6C;
    localparam logic [7:0] CMD_TIME_U  = 8'h4C;
    localparam logic [7:0] CMD_ALARM_L = 8'h61;
    localparam logic [7:0] CMD_ALARM_U = 8'h41;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;

    localparam logic [3:0] TENS_MAX = 4'd5;
    localparam logic [3:0] ONES_MAX = 4'd9;

    function automatic logic isDigit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    function automatic logic [3:0] digVal(input logic [7:0] b);
        return 4'(b - ASCII_0);
    endfunction

endpackage

// File: rtl/entry_timer.sv
// Inactivity counter: counts one-second strobes while entry is idle-waiting.
module entry_timer #(
    parameter int TIMEOUT_SEC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic strb,
    output logic timeout
);
    localparam int W = (TIMEOUT_SEC < 2) ? 1 : $clog2(TIMEOUT_SEC + 1);

    logic [W-1:0] cnt;

    // Fires on the strobe that would bring the count up to TIMEOUT_SEC.
    assign timeout = strb & ~clr & (cnt == W'(TIMEOUT_SEC - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || timeout)
            cnt <= '0;
        else if (strb)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/dientry.sv
// Keystroke entry sequencer: command byte + four digits -> per-digit load strobes.
// Optional inactivity abort is built when ENTRY_TIMEOUT_EN is defined.
module dientry
    import de_pkg::*;
#(
    parameter int TIMEOUT_SEC = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] de_byte,
    input  logic       de_valid,
    output logic       de_ready,
    input  logic       i_oneSecStrb,
    output logic       ld_time,
    output logic       ld_alarm,
    output logic       ldMtens,
    output logic       ldMones,
    output logic       ldStens,
    output logic       ldSones,
    output logic       valid_num,
    output logic [3:0] ld_num,
    output logic       de_freeze,
    output logic       de_done,
    output logic       de_abort
);
    state_t     state, stateNx;
    logic       modeAlarm, modeAlarmNx;
    logic       vldNx, doneNx, abortNx;
    logic [3:0] numNx, limit;
    logic       accept, isCmd, timeout;

    assign accept = de_valid & ~valid_num;
    assign isCmd  = (de_byte == CMD_TIME_L) || (de_byte == CMD_TIME_U) ||
                    (de_byte == CMD_ALARM_L) || (de_byte == CMD_ALARM_U);
    assign limit  = (state == MT || state == ST) ? TENS_MAX : ONES_MAX;

`ifdef ENTRY_TIMEOUT_EN
    entry_timer #(.TIMEOUT_SEC(TIMEOUT_SEC)) uTimer (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept | (state == IDLE)),
        .strb    (i_oneSecStrb),
        .timeout (timeout)
    );
`else
    logic unusedStrb;
    assign unusedStrb = i_oneSecStrb ^ (TIMEOUT_SEC == 0);
    assign timeout    = 1'b0;
`endif

    always_comb begin
        stateNx     = state;
        modeAlarmNx = modeAlarm;
        vldNx       = 1'b0;
        numNx       = ld_num;
        doneNx      = 1'b0;
        abortNx     = 1'b0;
        if (timeout) begin
            stateNx = IDLE;
            abortNx = 1'b1;
        end else if (valid_num) begin
            // The load cycle is over; move to the next digit.
            unique case (state)
                MT:      stateNx = MO;
                MO:      stateNx = ST;
                ST:      stateNx = SO;
                default: stateNx = IDLE;
            endcase
            doneNx = (state == SO);
        end else if (accept) begin
            if (isCmd) begin
                modeAlarmNx = (de_byte == CMD_ALARM_L) || (de_byte == CMD_ALARM_U);
                stateNx     = MT;
            end else if (state != IDLE) begin
                if (de_byte == ASCII_ESC) begin
                    stateNx = IDLE;
                    abortNx = 1'b1;
                end else if (isDigit(de_byte) && (digVal(de_byte) <= limit)) begin
                    vldNx = 1'b1;
                    numNx = digVal(de_byte);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            modeAlarm <= 1'b0;
            valid_num <= 1'b0;
            ld_num    <= 4'd0;
            de_done   <= 1'b0;
            de_abort  <= 1'b0;
        end else begin
            state     <= stateNx;
            modeAlarm <= modeAlarmNx;
            valid_num <= vldNx;
            ld_num    <= numNx;
            de_done   <= doneNx;
            de_abort  <= abortNx;
        end
    end

    assign de_ready  = ~valid_num;
    assign ld_time   = ~modeAlarm & (state != IDLE);
    assign ld_alarm  = modeAlarm & (state != IDLE);
    assign de_freeze = ld_time;
    assign ldMtens   = (state == MT);
    assign ldMones   = (state == MO);
    assign ldStens   = (state == ST);
    assign ldSones   = (state == SO);
endmodule
